aha_dma_axi_txn_guard: RTL and testbench
========================================

Name: aha_dma_axi_txn_guard

Overview:
- Sits on the DMA engine's AXI4 master port, between the DMA and the SoC interconnect. Observes and gates only the handshake signals; the payload wires bypass it at integration level.
- Limits outstanding write and read transactions.
- Runs a per-direction progress watchdog and flags error responses.
- Drives the DMA subsystem's abort interrupt (IRQ_ABORT), which the DMA integration currently ties low.

Parameters:
- MAX_OUTSTANDING, 4, max in-flight AW (and, separately, AR) transactions; range 1..15.
- TMO_W, 16, width of the timeout configuration and watchdog counters.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- S_AWVALID  in  1  AW valid from DMA
- S_AWREADY  out  1  AW ready to DMA
- M_AWVALID  out  1  AW valid to interconnect
- M_AWREADY  in  1  AW ready from interconnect
- S_ARVALID, S_ARREADY, M_ARVALID, M_ARREADY  same directions/widths as AW, for AR
- BVALID  in  1  write response valid
- BREADY  in  1  write response ready (driven by DMA)
- BRESP  in  2  write response code
- RVALID  in  1  read beat valid
- RREADY  in  1  read beat ready (driven by DMA)
- RLAST  in  1  last read beat
- RRESP  in  2  read response code
- CFG_TIMEOUT  in  TMO_W  stall limit in cycles; 0 disables watchdog
- CFG_HALT_ON_ERR  in  1  enter HALT on SLVERR/DECERR
- ERR_CLR  in  1  single-cycle pulse; clears error and leaves HALT
- IRQ_ABORT  out  1  level abort interrupt
- ERR_CODE  out  3  sticky cause of first error
- WR_OUTSTANDING  out  4  current write count
- RD_OUTSTANDING  out  4  current read count
- WR_DONE_CNT  out  32  completed writes (optional feature)
- RD_DONE_CNT  out  32  completed reads (optional feature)

Behaviour:
Reset and clock:
- One clock (ACLK); ARESETn asynchronous, active-low.
- On reset: counters 0, state RUN, IRQ_ABORT=0, ERR_CODE=0, watchdogs 0, WR_DONE_CNT/RD_DONE_CNT=0.

Gating (combinational, zero latency):
- aw_ok = (state==RUN) && (wr_cnt < MAX_OUTSTANDING).
- M_AWVALID = S_AWVALID & aw_ok; S_AWREADY = M_AWREADY & aw_ok. AR is identical with rd_cnt.
- aw_ok may deassert only at a clock edge, after an accepted handshake has taken the count to the limit, or on entry to HALT. An AW/AR valid already presented to the interconnect is held until it is accepted; if a timeout or error causes HALT entry while valid is pending, the interconnect side is not withdrawn until that transaction is accepted.

Counters:
- wr_cnt increments on an M_AW handshake and decrements on a B handshake (BVALID&BREADY).
- rd_cnt increments on an M_AR handshake and decrements on an R handshake with RLAST.
- Increment and decrement in the same cycle: count unchanged.
- Decrement at 0 (underflow): count stays 0; ERR_CODE=5 (wr) or 6 (rd).
- Count never exceeds MAX_OUTSTANDING.

Watchdog, per direction:
- Counter clears when cnt==0 or on any B handshake (wr) / any R beat (rd). Otherwise it increments, saturating.
- When CFG_TIMEOUT!=0 and counter==CFG_TIMEOUT: error, ERR_CODE=1 (wr) or 2 (rd).

Response errors:
- BRESP[1] on a B handshake: ERR_CODE=3. RRESP[1] on an R beat: ERR_CODE=4.
- Response errors cause HALT only if CFG_HALT_ON_ERR=1. Timeouts and underflows always cause HALT.

Error FSM, states RUN and HALT:
- RUN→HALT on a halting error (next edge).
- HALT→RUN on ERR_CLR; this clears ERR_CODE and both watchdogs. Counters are kept.
- In HALT, responses are still observed and counted.
- IRQ_ABORT = (state==HALT) | (ERR_CODE!=0).
- ERR_CODE records the first error only. On simultaneous errors, the lower code wins.
- ERR_CLR in the same cycle as a new error: the new error wins.
- ERR_CLR in RUN clears ERR_CODE.

Optional Feature:
- AHA_DMA_TXN_STATS_EN defined: WR_DONE_CNT/RD_DONE_CNT increment on each B handshake / each R beat with RLAST, wrapping at 2^32; ERR_CLR does not clear them.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Decomposition:
- Package aha_dma_pkg holds:
  - err_code_t (NONE=0, WR_TMO=1, RD_TMO=2, WR_RESP=3, RD_RESP=4, WR_UNDF=5, RD_UNDF=6)
  - state_t (RUN, HALT)
  - AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11
- Sub-module aha_dma_txn_watchdog: one instance per direction. Inputs: busy, progress, limit. Output: timeout pulse.

Test Plan:
- MAX=4, DMA issues 6 back-to-back AWs with M_AWREADY=1 and no B → exactly 4 M_AW handshakes; S_AWREADY=0 from the 5th; WR_OUTSTANDING=4. One B → 5th AW accepted the next cycle.
- Same-cycle AR handshake and R beat with RLAST at rd_cnt=2 → rd_cnt stays 2.
- CFG_TIMEOUT=10, one AW outstanding, no B → ERR_CODE=1 and IRQ_ABORT=1 after 10 stall cycles; new AWs blocked. ERR_CLR → RUN; AW accepted again.
- BRESP=2'b10 with CFG_HALT_ON_ERR=0 → ERR_CODE=3, IRQ_ABORT=1, no halt. Repeat with CFG_HALT_ON_ERR=1 → HALT.
- B handshake with wr_cnt=0 → ERR_CODE=5, wr_cnt stays 0, HALT.
- ARESETn asserted mid-burst with rd_cnt=3 → all outputs return to reset values immediately. With AHA_DMA_TXN_STATS_EN: 7 completed reads → RD_DONE_CNT=7.

Source files
------------

// File: rtl/aha_dma_pkg.sv
// Shared types and helpers for the DMA AXI transaction guard.
// Optional build macro used by the guard: AHA_DMA_TXN_STATS_EN.
package aha_dma_pkg;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    WR_TMO  = 3'd1,
    RD_TMO  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4,
    WR_UNDF = 3'd5,
    RD_UNDF = 3'd6
  } err_code_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Lowest-numbered raised flag wins when several errors land together.
  function automatic err_code_t first_err(input logic [6:1] flags);
    err_code_t code;
    code = NONE;
    for (int i = 6; i >= 1; i--) begin
      if (flags[i]) code = err_code_t'(3'(i));
    end
    return code;
  endfunction

  // Outstanding-count update; a simultaneous issue and completion cancel,
  // and a completion at zero leaves the count at zero.
  function automatic logic [3:0] cnt_next(input logic [3:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [3:0] n;
    if (inc && !dec) begin
      n = cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      n = cnt - 4'd1;
    end else begin
      n = cnt;
    end
    return n;
  endfunction

endpackage

// File: rtl/aha_dma_txn_watchdog.sv
// Per-direction progress watchdog: counts stalled cycles while transactions
// are outstanding and pulses timeout when the count reaches the limit.
module aha_dma_txn_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             busy,
  input  logic             progress,
  input  logic [TMO_W-1:0] limit,
  output logic             timeout
);

  logic [TMO_W-1:0] r_cnt;

  // Stall counter: cleared when idle, on progress or on error clear; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || !busy || progress) begin
      r_cnt <= '0;
    end else if (r_cnt != {TMO_W{1'b1}}) begin
      r_cnt <= r_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // The counter keeps moving past the limit, so equality holds for one cycle.
  assign timeout = (limit != '0) && (r_cnt == limit);

endmodule

// File: rtl/aha_dma_axi_txn_guard.sv
// AXI4 handshake guard for the DMA master port: limits outstanding AW/AR,
// watches for stalls and error responses, and drives the abort interrupt.
// Optional build macro: AHA_DMA_TXN_STATS_EN (completion counters).
module aha_dma_axi_txn_guard
  import aha_dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TMO_W           = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             S_AWVALID,
  output logic             S_AWREADY,
  output logic             M_AWVALID,
  input  logic             M_AWREADY,
  input  logic             S_ARVALID,
  output logic             S_ARREADY,
  output logic             M_ARVALID,
  input  logic             M_ARREADY,
  input  logic             BVALID,
  input  logic             BREADY,
  input  logic [1:0]       BRESP,
  input  logic             RVALID,
  input  logic             RREADY,
  input  logic             RLAST,
  input  logic [1:0]       RRESP,
  input  logic [TMO_W-1:0] CFG_TIMEOUT,
  input  logic             CFG_HALT_ON_ERR,
  input  logic             ERR_CLR,
  output logic             IRQ_ABORT,
  output logic [2:0]       ERR_CODE,
  output logic [3:0]       WR_OUTSTANDING,
  output logic [3:0]       RD_OUTSTANDING,
  output logic [31:0]      WR_DONE_CNT,
  output logic [31:0]      RD_DONE_CNT
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

  state_t     r_state, w_state_nxt;
  err_code_t  r_err, w_err_nxt, w_new_err;
  logic [3:0] r_wr_cnt, r_rd_cnt;
  logic       r_aw_pend, r_ar_pend;
  logic       w_aw_ok, w_ar_ok, w_aw_hs, w_ar_hs, w_b_hs, w_r_hs, w_r_last;
  logic       w_b_err, w_r_err, w_wr_undf, w_rd_undf, w_wr_tmo, w_rd_tmo;
  logic       w_halt_err, w_wd_clr;
  logic [6:1] w_err_flags;

  // A valid already shown to the interconnect stays gated open until accepted.
  assign w_aw_ok   = r_aw_pend | ((r_state == RUN) & (r_wr_cnt < MAX_C));
  assign w_ar_ok   = r_ar_pend | ((r_state == RUN) & (r_rd_cnt < MAX_C));
  assign M_AWVALID = S_AWVALID & w_aw_ok;
  assign S_AWREADY = M_AWREADY & w_aw_ok;
  assign M_ARVALID = S_ARVALID & w_ar_ok;
  assign S_ARREADY = M_ARREADY & w_ar_ok;

  assign w_aw_hs   = M_AWVALID & M_AWREADY;
  assign w_ar_hs   = M_ARVALID & M_ARREADY;
  assign w_b_hs    = BVALID & BREADY;
  assign w_r_hs    = RVALID & RREADY;
  assign w_r_last  = w_r_hs & RLAST;
  assign w_b_err   = w_b_hs & ((BRESP == AXI_RESP_SLVERR) | (BRESP == AXI_RESP_DECERR));
  assign w_r_err   = w_r_hs & ((RRESP == AXI_RESP_SLVERR) | (RRESP == AXI_RESP_DECERR));
  assign w_wr_undf = w_b_hs & ~w_aw_hs & (r_wr_cnt == 4'd0);
  assign w_rd_undf = w_r_last & ~w_ar_hs & (r_rd_cnt == 4'd0);
  assign w_wd_clr  = ERR_CLR & (r_state == HALT);

  aha_dma_txn_watchdog #(.TMO_W(TMO_W)) u_wd_wr (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .clr      (w_wd_clr),
    .busy     (r_wr_cnt != 4'd0),
    .progress (w_b_hs),
    .limit    (CFG_TIMEOUT),
    .timeout  (w_wr_tmo)
  );

  aha_dma_txn_watchdog #(.TMO_W(TMO_W)) u_wd_rd (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .clr      (w_wd_clr),
    .busy     (r_rd_cnt != 4'd0),
    .progress (w_r_hs),
    .limit    (CFG_TIMEOUT),
    .timeout  (w_rd_tmo)
  );

  assign w_err_flags = {w_rd_undf, w_wr_undf, w_r_err, w_b_err, w_rd_tmo, w_wr_tmo};
  assign w_new_err   = first_err(w_err_flags);
  assign w_halt_err  = w_wr_tmo | w_rd_tmo | w_wr_undf | w_rd_undf |
                       (CFG_HALT_ON_ERR & (w_b_err | w_r_err));

  // Error FSM next state and sticky first-error code; a new error beats ERR_CLR.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    if (w_halt_err) begin
      w_state_nxt = HALT;
    end else if (ERR_CLR) begin
      w_state_nxt = RUN;
    end else begin
      w_state_nxt = r_state;
    end
    if ((w_new_err != NONE) && ((r_err == NONE) || ERR_CLR)) begin
      w_err_nxt = w_new_err;
    end else if (ERR_CLR) begin
      w_err_nxt = NONE;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // State, error code, outstanding counts and pending-valid flags.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= RUN;
      r_err     <= NONE;
      r_wr_cnt  <= 4'd0;
      r_rd_cnt  <= 4'd0;
      r_aw_pend <= 1'b0;
      r_ar_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_err     <= w_err_nxt;
      r_wr_cnt  <= cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
      r_rd_cnt  <= cnt_next(r_rd_cnt, w_ar_hs, w_r_last);
      r_aw_pend <= M_AWVALID & ~M_AWREADY;
      r_ar_pend <= M_ARVALID & ~M_ARREADY;
    end
  end

  assign IRQ_ABORT      = (r_state == HALT) | (r_err != NONE);
  assign ERR_CODE       = r_err;
  assign WR_OUTSTANDING = r_wr_cnt;
  assign RD_OUTSTANDING = r_rd_cnt;

`ifdef AHA_DMA_TXN_STATS_EN
  logic [31:0] r_wr_done, r_rd_done;

  // Completion counters; they wrap and survive ERR_CLR.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_done <= 32'd0;
      r_rd_done <= 32'd0;
    end else begin
      r_wr_done <= r_wr_done + {31'd0, w_b_hs};
      r_rd_done <= r_rd_done + {31'd0, w_r_last};
    end
  end

  assign WR_DONE_CNT = r_wr_done;
  assign RD_DONE_CNT = r_rd_done;
`else
  assign WR_DONE_CNT = 32'd0;
  assign RD_DONE_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_aha_dma_axi_txn_guard.sv
// Self-checking bench for aha_dma_axi_txn_guard: directed scenarios followed
// by random traffic, all compared against a transaction-level reference model.
module tb_aha_dma_axi_txn_guard;

  localparam int MAX = 4;
  localparam int TW  = 16;
`ifdef AHA_DMA_TXN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          S_AWVALID, M_AWREADY, S_ARVALID, M_ARREADY;
  logic          BVALID, BREADY, RVALID, RREADY, RLAST;
  logic [1:0]    BRESP, RRESP;
  logic [TW-1:0] CFG_TIMEOUT;
  logic          CFG_HALT_ON_ERR, ERR_CLR;
  logic          S_AWREADY, M_AWVALID, S_ARREADY, M_ARVALID, IRQ_ABORT;
  logic [2:0]    ERR_CODE;
  logic [3:0]    WR_OUTSTANDING, RD_OUTSTANDING;
  logic [31:0]   WR_DONE_CNT, RD_DONE_CNT;

  always #5 ACLK = ~ACLK;

  aha_dma_axi_txn_guard #(.MAX_OUTSTANDING(MAX), .TMO_W(TW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .CFG_TIMEOUT(CFG_TIMEOUT), .CFG_HALT_ON_ERR(CFG_HALT_ON_ERR), .ERR_CLR(ERR_CLR),
    .IRQ_ABORT(IRQ_ABORT), .ERR_CODE(ERR_CODE),
    .WR_OUTSTANDING(WR_OUTSTANDING), .RD_OUTSTANDING(RD_OUTSTANDING),
    .WR_DONE_CNT(WR_DONE_CNT), .RD_DONE_CNT(RD_DONE_CNT)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int obs_aw_hs = 0;

  // Reference model: transaction counts, halt flag, first error, stall ages.
  int          m_wcnt, m_rcnt, m_err, m_wage, m_rage;
  bit          m_halt, m_awpend, m_arpend;
  int unsigned m_wdone, m_rdone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_err = 0; m_wage = 0; m_rage = 0;
    m_halt = 0; m_awpend = 0; m_arpend = 0; m_wdone = 0; m_rdone = 0;
  endtask

  task automatic idle();
    S_AWVALID = 0; M_AWREADY = 0; S_ARVALID = 0; M_ARREADY = 0;
    BVALID = 0; BREADY = 0; BRESP = 2'b00; RVALID = 0; RREADY = 0;
    RLAST = 0; RRESP = 2'b00; ERR_CLR = 0;
  endtask

  // One clock: check gating mid-cycle, advance the model, check state after the edge.
  task automatic cycle();
    bit aw_ok, ar_ok, e_awv, e_awr, e_arv, e_arr, aw_hs, ar_hs, b_hs, r_beat, r_last, halting;
    int errs[$];
    int first, nw, nr, wage_n, rage_n, lim;
    #3;
    aw_ok = m_awpend || (!m_halt && m_wcnt < MAX);
    ar_ok = m_arpend || (!m_halt && m_rcnt < MAX);
    e_awv = S_AWVALID && aw_ok;  e_awr = M_AWREADY && aw_ok;
    e_arv = S_ARVALID && ar_ok;  e_arr = M_ARREADY && ar_ok;
    chk("m_awvalid", 32'(M_AWVALID), 32'(e_awv));
    chk("s_awready", 32'(S_AWREADY), 32'(e_awr));
    chk("m_arvalid", 32'(M_ARVALID), 32'(e_arv));
    chk("s_arready", 32'(S_ARREADY), 32'(e_arr));
    if (M_AWVALID && M_AWREADY) obs_aw_hs++;
    aw_hs  = e_awv && M_AWREADY;
    ar_hs  = e_arv && M_ARREADY;
    b_hs   = BVALID && BREADY;
    r_beat = RVALID && RREADY;
    r_last = r_beat && RLAST;
    lim    = int'(CFG_TIMEOUT);
    if (lim != 0 && m_wage == lim) errs.push_back(1);
    if (lim != 0 && m_rage == lim) errs.push_back(2);
    if (b_hs && BRESP[1]) errs.push_back(3);
    if (r_beat && RRESP[1]) errs.push_back(4);
    nw = m_wcnt + int'(aw_hs) - int'(b_hs);
    nr = m_rcnt + int'(ar_hs) - int'(r_last);
    if (nw < 0) begin errs.push_back(5); nw = 0; end
    if (nr < 0) begin errs.push_back(6); nr = 0; end
    halting = 0;
    first = 0;
    foreach (errs[i]) begin
      if (errs[i] == 1 || errs[i] == 2 || errs[i] == 5 || errs[i] == 6) halting = 1;
      if ((errs[i] == 3 || errs[i] == 4) && CFG_HALT_ON_ERR) halting = 1;
      if (first == 0 || errs[i] < first) first = errs[i];
    end
    // stall ages, measured against the count before this edge
    wage_n = (m_wcnt == 0 || b_hs) ? 0 : ((m_wage < 65535) ? m_wage + 1 : m_wage);
    rage_n = (m_rcnt == 0 || r_beat) ? 0 : ((m_rage < 65535) ? m_rage + 1 : m_rage);
    if (ERR_CLR && m_halt) begin wage_n = 0; rage_n = 0; end
    if (first != 0 && (m_err == 0 || ERR_CLR)) m_err = first;
    else if (ERR_CLR) m_err = 0;
    if (halting) m_halt = 1;
    else if (ERR_CLR) m_halt = 0;
    m_wcnt = nw; m_rcnt = nr; m_wage = wage_n; m_rage = rage_n;
    m_awpend = e_awv && !M_AWREADY;
    m_arpend = e_arv && !M_ARREADY;
    if (b_hs) m_wdone++;
    if (r_last) m_rdone++;
    @(posedge ACLK);
    #1;
    chk("err_code", 32'(ERR_CODE), 32'(m_err));
    chk("irq_abort", 32'(IRQ_ABORT), 32'(m_halt || m_err != 0));
    chk("wr_outstanding", 32'(WR_OUTSTANDING), 32'(m_wcnt));
    chk("rd_outstanding", 32'(RD_OUTSTANDING), 32'(m_rcnt));
    chk("wr_done_cnt", WR_DONE_CNT, STATS ? m_wdone : 32'd0);
    chk("rd_done_cnt", RD_DONE_CNT, STATS ? m_rdone : 32'd0);
  endtask

  initial begin
    idle();
    CFG_TIMEOUT = 16'd0; CFG_HALT_ON_ERR = 1'b0;
    ARESETn = 1'b0;
    model_reset();
    #2;
    chk("rst_err", 32'(ERR_CODE), 32'd0);
    chk("rst_irq", 32'(IRQ_ABORT), 32'd0);
    chk("rst_wr", 32'(WR_OUTSTANDING), 32'd0);
    chk("rst_rd", 32'(RD_OUTSTANDING), 32'd0);
    #10 ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Outstanding-write limit: six back-to-back AWs, no B.
    S_AWVALID = 1; M_AWREADY = 1;
    repeat (6) cycle();
    chk("aw_hs_at_limit", 32'(obs_aw_hs), 32'd4);
    chk("s_awready_at_limit", 32'(S_AWREADY), 32'd0);
    chk("wr_out_at_limit", 32'(WR_OUTSTANDING), 32'd4);
    BVALID = 1; BREADY = 1;
    cycle();
    BVALID = 0; BREADY = 0;
    cycle();
    chk("aw_after_b", 32'(obs_aw_hs), 32'd5);
    S_AWVALID = 0; M_AWREADY = 0; BVALID = 1; BREADY = 1;
    repeat (4) cycle();
    idle();

    // Same-cycle AR issue and last R beat at rd_cnt=2.
    S_ARVALID = 1; M_ARREADY = 1;
    repeat (2) cycle();
    RVALID = 1; RREADY = 1; RLAST = 1;
    cycle();
    chk("rd_same_cycle", 32'(RD_OUTSTANDING), 32'd2);
    S_ARVALID = 0; M_ARREADY = 0;
    repeat (2) cycle();
    idle();

    // Write watchdog timeout with one AW outstanding.
    CFG_TIMEOUT = 16'd10;
    S_AWVALID = 1; M_AWREADY = 1;
    cycle();
    idle();
    repeat (10) cycle();
    chk("no_early_tmo", 32'(ERR_CODE), 32'd0);
    cycle();
    chk("wr_tmo_code", 32'(ERR_CODE), 32'd1);
    chk("wr_tmo_irq", 32'(IRQ_ABORT), 32'd1);
    S_AWVALID = 1; M_AWREADY = 1; #1;
    chk("aw_blocked_halt", 32'(M_AWVALID), 32'd0);
    S_AWVALID = 0; ERR_CLR = 1;
    cycle();
    ERR_CLR = 0; S_AWVALID = 1; #1;
    chk("aw_after_clr", 32'(M_AWVALID), 32'd1);
    cycle();
    idle(); CFG_TIMEOUT = 16'd0;
    BVALID = 1; BREADY = 1;
    repeat (2) cycle();
    idle();

    // SLVERR write response, first without then with halt-on-error.
    S_AWVALID = 1; M_AWREADY = 1;
    cycle();
    idle(); BVALID = 1; BREADY = 1; BRESP = 2'b10;
    cycle();
    chk("bresp_code", 32'(ERR_CODE), 32'd3);
    chk("bresp_irq", 32'(IRQ_ABORT), 32'd1);
    idle(); S_AWVALID = 1; M_AWREADY = 1; #1;
    chk("bresp_no_halt", 32'(M_AWVALID), 32'd1);
    cycle();
    idle(); ERR_CLR = 1;
    cycle();
    idle(); CFG_HALT_ON_ERR = 1; BVALID = 1; BREADY = 1; BRESP = 2'b10;
    cycle();
    idle(); S_AWVALID = 1; M_AWREADY = 1; #1;
    chk("bresp_halt", 32'(M_AWVALID), 32'd0);
    idle(); ERR_CLR = 1;
    cycle();
    idle(); CFG_HALT_ON_ERR = 0;

    // Write underflow: B with nothing outstanding.
    BVALID = 1; BREADY = 1;
    cycle();
    chk("undf_code", 32'(ERR_CODE), 32'd5);
    chk("undf_wr", 32'(WR_OUTSTANDING), 32'd0);
    idle(); S_AWVALID = 1; #1;
    chk("undf_halt", 32'(M_AWVALID), 32'd0);
    idle(); ERR_CLR = 1;
    cycle();
    idle();

    // Asynchronous reset mid-burst with three reads outstanding.
    S_ARVALID = 1; M_ARREADY = 1;
    repeat (3) cycle();
    idle(); RVALID = 1; RREADY = 1;
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_rd", 32'(RD_OUTSTANDING), 32'd0);
    chk("arst_wr", 32'(WR_OUTSTANDING), 32'd0);
    chk("arst_err", 32'(ERR_CODE), 32'd0);
    chk("arst_irq", 32'(IRQ_ABORT), 32'd0);
    chk("arst_rd_done", RD_DONE_CNT, 32'd0);
    chk("arst_wr_done", WR_DONE_CNT, 32'd0);
    model_reset();
    idle();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Seven complete reads.
    for (int i = 0; i < 7; i++) begin
      idle(); S_ARVALID = 1; M_ARREADY = 1;
      cycle();
      idle(); RVALID = 1; RREADY = 1; RLAST = 1;
      cycle();
    end
    idle();
    chk("rd_done_7", RD_DONE_CNT, STATS ? 32'd7 : 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if (k % 100 == 0) begin
        CFG_TIMEOUT     = 16'($urandom_range(0, 12));
        CFG_HALT_ON_ERR = 1'($urandom_range(0, 1));
      end
      S_AWVALID = 1'($urandom_range(0, 1));
      M_AWREADY = 1'($urandom_range(0, 1));
      S_ARVALID = 1'($urandom_range(0, 1));
      M_ARREADY = 1'($urandom_range(0, 1));
      BVALID    = ($urandom_range(0, 2) == 0);
      BREADY    = 1'($urandom_range(0, 1));
      BRESP     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      RVALID    = ($urandom_range(0, 1) == 0);
      RREADY    = 1'($urandom_range(0, 1));
      RLAST     = 1'($urandom_range(0, 1));
      RRESP     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ERR_CLR   = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
